memory_weight_stream: RTL and testbench
=======================================

Name: memory_weight_stream

Overview:
- Next-generation weight store for the accelerator.
- Holds one LAYER_SIZE x LAYER_SIZE weight matrix per layer, in LAYER_SIZE row banks.
- A handshaked stream loader with auto-incrementing addresses fills one whole layer per load command.
- A pipelined read port returns one full column (one word per row bank) per request, with a valid flag, to the MAC array.

Parameters:
- LAYER_SIZE, 8, nodes per layer; number of row banks; matrix is LAYER_SIZE x LAYER_SIZE.
- LAYER_DEPTH, 4, number of layers stored.
- BIT_SIZE, 16, weight word width.
- PIPE_STAGES, 1, extra read pipeline registers (0..2); total read latency is 1+PIPE_STAGES.
- INIT_FILE, "", optional memory init file passed to every bank.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- load_start  in  1  one-cycle pulse; begin loading layer load_layer
- load_layer  in  $clog2(LAYER_DEPTH)  target layer, sampled on accepted load_start
- load_abort  in  1  terminate an active load
- load_busy  out  1  high while loading
- load_done  out  1  one-cycle pulse after the last word is written
- s_valid  in  1  weight stream valid
- s_ready  out  1  weight stream ready
- s_data  in  BIT_SIZE  weight word
- rd_en  in  1  read request
- rd_layer  in  $clog2(LAYER_DEPTH)  read layer
- rd_node  in  $clog2(LAYER_SIZE)  read column k
- rd_valid  out  1  rd_data valid
- rd_data  out  [LAYER_SIZE][BIT_SIZE]  column k; element j = W[layer][j][k]

Behaviour:
Reset (rst_n low, async)
- FSM goes to IDLE.
- load_busy=0, load_done=0, s_ready=0, rd_valid=0, rd_data=0.
- Row/column counters and read pipeline valid bits clear.
- Memory contents are not cleared.

FSM states: IDLE, LOAD, DONE.
- IDLE: load_start=1 latches load_layer, clears row counter j and column counter k, then moves to LOAD.
- LOAD: load_busy=1 and s_ready=1.
  - A beat is accepted when s_valid & s_ready.
  - Each beat writes s_data into bank j at address {layer, k}.
  - Then k increments; when k=LAYER_SIZE-1, k wraps to 0 and j increments.
  - Stream order is row-major: j outer, k inner; LAYER_SIZE*LAYER_SIZE beats total.
  - The beat with j=k=LAYER_SIZE-1 moves the FSM to DONE.
- DONE: load_done=1 for exactly one cycle, load_busy=0, s_ready=0, then return to IDLE.
- load_start while in LOAD or DONE is ignored.
- load_abort in LOAD: return to IDLE next cycle with no load_done. A beat accepted in the same cycle is still written. Words already written remain.
- load_abort in IDLE or DONE is ignored.
- s_ready is 0 outside LOAD; beats presented then are not consumed.

Read path
- rd_en is accepted every cycle, independent of the load state; it is a fully pipelined, one-per-cycle port.
- Memory read takes 1 cycle, followed by PIPE_STAGES registers.
- rd_valid rises exactly 1+PIPE_STAGES cycles after rd_en.
- rd_data equals the column when rd_valid=1 and is forced to 0 when rd_valid=0.
- Read-during-write to the same bank and address returns the OLD word.

Addressing
- Bank address is {layer, node}, so bank depth is 2**($clog2(LAYER_DEPTH)+$clog2(LAYER_SIZE)).
- Out-of-range indices (non-power-of-two sizes) are unspecified; the bench must not drive them.
- Write decode: bank j write enable = accepted beat & (row counter == j); exactly one bank is written per beat.

Decomposition:
- Package weight_mem_pkg:
  - load FSM state enum (IDLE/LOAD/DONE);
  - width localparams (layer/node address widths);
  - typedef for the column bus.
- Sub-module: reuse the existing dual-port cell memory_cell_dual, one instance per row bank, in a generate loop.
- Counters, FSM and read pipeline live in the top module.

Test Plan (LAYER_SIZE=4, LAYER_DEPTH=4, BIT_SIZE=8, PIPE_STAGES=1):
- Load layer 2 with s_valid held high, data 0..15 → s_ready high 16 cycles, load_done pulses once after beat 15. rd_en with layer 2, node 1 → rd_valid 2 cycles later, rd_data={13,9,5,1} (j=3..0).
- Stream with s_valid toggling 1/0 and data 0x10..0x1F → 16 beats accepted, no skip or duplicate; read all 4 columns back and match.
- Back-to-back rd_en for 4 cycles, nodes 0..3 → 4 consecutive rd_valid cycles, columns in order; rd_data=0 on the cycles around them.
- Abort after 6 beats into layer 1 (preloaded 0xAA) → no load_done, FSM IDLE. Bank 1 cols 0..1 and bank 0 hold new data; remaining words still 0xAA.
- load_start while busy is ignored. Read of {layer 2, node 3} in the same cycle as the write beat at j=3, k=3 returns the old value.
- Assert rst_n mid-load and mid-read → all outputs 0 immediately. A new load then completes normally.

Source files
------------

// File: rtl/weight_mem_pkg.sv
// Shared sizing helpers, load FSM encoding and column bus type for the layered weight store.
package weight_mem_pkg;

    // Guard against zero-width indices when a dimension has a single entry.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_e;

    localparam int DEF_LAYER_SIZE  = 8;
    localparam int DEF_LAYER_DEPTH = 4;
    localparam int DEF_BIT_SIZE    = 16;
    localparam int NODE_AW         = idx_width(DEF_LAYER_SIZE);
    localparam int LAYER_AW        = idx_width(DEF_LAYER_DEPTH);

    typedef logic [DEF_LAYER_SIZE-1:0][DEF_BIT_SIZE-1:0] column_t;

endpackage

// File: rtl/memory_cell_dual.sv
// Simple dual-port RAM cell: one write port, one registered read port.
// A read that collides with a write to the same address returns the old word.
module memory_cell_dual #(
    parameter int    DATA_W    = 16,
    parameter int    ADDR_W    = 5,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/memory_weight_stream.sv
// Layered weight store: a stream loader fills one LAYER_SIZE x LAYER_SIZE matrix per command
// into per-row banks, and a pipelined port returns one full column per read request.
module memory_weight_stream
    import weight_mem_pkg::*;
#(
    parameter int    LAYER_SIZE  = 8,
    parameter int    LAYER_DEPTH = 4,
    parameter int    BIT_SIZE    = 16,
    parameter int    PIPE_STAGES = 1,
    parameter string INIT_FILE   = "",
    localparam int   LW          = idx_width(LAYER_DEPTH),
    localparam int   NW          = idx_width(LAYER_SIZE)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               load_start,
    input  logic [LW-1:0]                      load_layer,
    input  logic                               load_abort,
    output logic                               load_busy,
    output logic                               load_done,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic [BIT_SIZE-1:0]                s_data,
    input  logic                               rd_en,
    input  logic [LW-1:0]                      rd_layer,
    input  logic [NW-1:0]                      rd_node,
    output logic                               rd_valid,
    output logic [LAYER_SIZE-1:0][BIT_SIZE-1:0] rd_data
);

    localparam int            AW       = LW + NW;
    localparam logic [NW-1:0] LAST_IDX = NW'(LAYER_SIZE - 1);

    logic [1:0]    state;
    logic [LW-1:0] wr_layer;
    logic [NW-1:0] row_cnt;
    logic [NW-1:0] col_cnt;
    logic          beat;
    logic          last_beat;

    logic [LAYER_SIZE-1:0][BIT_SIZE-1:0] mem_col;
    logic                                mem_valid;
    logic [LAYER_SIZE-1:0][BIT_SIZE-1:0] out_data;
    logic                                out_valid;

    assign s_ready   = (state == ST_LOAD);
    assign load_busy = (state == ST_LOAD);
    assign load_done = (state == ST_DONE);
    assign beat      = s_ready && s_valid;
    assign last_beat = beat && (row_cnt == LAST_IDX) && (col_cnt == LAST_IDX);

    // Abort takes priority over completion, but the beat of that cycle is still written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            wr_layer <= '0;
            row_cnt  <= '0;
            col_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_start) begin
                        state    <= ST_LOAD;
                        wr_layer <= load_layer;
                        row_cnt  <= '0;
                        col_cnt  <= '0;
                    end
                end
                ST_LOAD: begin
                    if (beat) begin
                        if (col_cnt == LAST_IDX) begin
                            col_cnt <= '0;
                            row_cnt <= row_cnt + NW'(1);
                        end else begin
                            col_cnt <= col_cnt + NW'(1);
                        end
                    end
                    if (load_abort) begin
                        state <= ST_IDLE;
                    end else if (last_beat) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    for (genvar j = 0; j < LAYER_SIZE; j++) begin : g_bank
        memory_cell_dual #(
            .DATA_W    (BIT_SIZE),
            .ADDR_W    (AW),
            .INIT_FILE (INIT_FILE)
        ) u_cell (
            .clk     (clk),
            .wr_en   (beat && (row_cnt == NW'(j))),
            .wr_addr ({wr_layer, col_cnt}),
            .wr_data (s_data),
            .rd_en   (rd_en),
            .rd_addr ({rd_layer, rd_node}),
            .rd_data (mem_col[j])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid <= 1'b0;
        end else begin
            mem_valid <= rd_en;
        end
    end

    if (PIPE_STAGES == 0) begin : g_nopipe
        assign out_valid = mem_valid;
        assign out_data  = mem_col;
    end else begin : g_pipe
        logic [PIPE_STAGES-1:0]              vld;
        logic [LAYER_SIZE-1:0][BIT_SIZE-1:0] dat [PIPE_STAGES];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld <= '0;
                for (int s = 0; s < PIPE_STAGES; s++) begin
                    dat[s] <= '0;
                end
            end else begin
                vld[0] <= mem_valid;
                dat[0] <= mem_col;
                for (int s = 1; s < PIPE_STAGES; s++) begin
                    vld[s] <= vld[s-1];
                    dat[s] <= dat[s-1];
                end
            end
        end

        assign out_valid = vld[PIPE_STAGES-1];
        assign out_data  = dat[PIPE_STAGES-1];
    end

    // Column bus is held at zero whenever it does not carry a valid column.
    assign rd_valid = out_valid;
    assign rd_data  = out_valid ? out_data : '0;

endmodule

// File: tb/tb_memory_weight_stream.sv
// Bench for memory_weight_stream: directed and randomized traffic checked every cycle
// against a matrix-level model of loads, aborts and delayed column reads.
module tb_memory_weight_stream;

    localparam int LS = 4;
    localparam int LD = 4;
    localparam int BS = 8;
    localparam int PS = 1;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    load_start = 1'b0;
    logic [1:0]              load_layer = '0;
    logic                    load_abort = 1'b0;
    logic                    load_busy;
    logic                    load_done;
    logic                    s_valid = 1'b0;
    logic                    s_ready;
    logic [BS-1:0]           s_data = '0;
    logic                    rd_en = 1'b0;
    logic [1:0]              rd_layer = '0;
    logic [1:0]              rd_node = '0;
    logic                    rd_valid;
    logic [LS-1:0][BS-1:0]   rd_data;

    memory_weight_stream #(
        .LAYER_SIZE  (LS),
        .LAYER_DEPTH (LD),
        .BIT_SIZE    (BS),
        .PIPE_STAGES (PS),
        .INIT_FILE   ("")
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_layer (load_layer),
        .load_abort (load_abort),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .rd_en      (rd_en),
        .rd_layer   (rd_layer),
        .rd_node    (rd_node),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data)
    );

    always #5 clk = ~clk;

    // Reference model: W[layer][row][col], load progress as a beat count, read delay line.
    logic [BS-1:0]         wm [LD][LS][LS];
    bit                    m_active;
    bit                    m_done;
    int                    m_layer;
    int                    m_count;
    bit [PS:0]             rq_valid;
    logic [LS-1:0][BS-1:0] rq_data [PS+1];

    int n_checks = 0;
    int n_pass   = 0;
    int done_seen = 0;

    task automatic checkValue(string tag, logic [63:0] obs, logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic modelReset();
        m_active = 1'b0;
        m_done   = 1'b0;
        rq_valid = '0;
        for (int s = 0; s <= PS; s++) rq_data[s] = '0;
    endtask

    task automatic modelEdge();
        logic [LS-1:0][BS-1:0] col;
        if (!rst_n) begin
            modelReset();
            return;
        end
        for (int s = PS; s > 0; s--) begin
            rq_valid[s] = rq_valid[s-1];
            rq_data[s]  = rq_data[s-1];
        end
        for (int j = 0; j < LS; j++) col[j] = wm[rd_layer][j][rd_node];
        rq_valid[0] = rd_en;
        rq_data[0]  = col;
        if (m_active) begin
            if (s_valid) begin
                wm[m_layer][m_count / LS][m_count % LS] = s_data;
                m_count++;
            end
            if (load_abort) begin
                m_active = 1'b0;
            end else if (m_count == LS * LS) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (load_start) begin
            m_active = 1'b1;
            m_layer  = int'(load_layer);
            m_count  = 0;
        end
    endtask

    task automatic checkOutput(string tag);
        logic [LS-1:0][BS-1:0] exp_data;
        exp_data = rq_valid[PS] ? rq_data[PS] : '0;
        checkValue({tag, ".load_busy"}, 64'(load_busy), 64'(m_active));
        checkValue({tag, ".s_ready"},   64'(s_ready),   64'(m_active));
        checkValue({tag, ".load_done"}, 64'(load_done), 64'(m_done));
        checkValue({tag, ".rd_valid"},  64'(rd_valid),  64'(rq_valid[PS]));
        checkValue({tag, ".rd_data"},   64'(rd_data),   64'(exp_data));
    endtask

    task automatic tick();
        modelEdge();
        @(posedge clk);
        #1;
        if (load_done) done_seen++;
        checkOutput("cycle");
    endtask

    task automatic applyStimulus(bit ls, int ll, bit la, bit sv, int sd, bit re, int rl, int rn);
        load_start = ls;
        load_layer = 2'(ll);
        load_abort = la;
        s_valid    = sv;
        s_data     = BS'(sd);
        rd_en      = re;
        rd_layer   = 2'(rl);
        rd_node    = 2'(rn);
        tick();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [LS-1:0][BS-1:0] exp_col;
        int   ready_cycles;
        int   beats;
        bit   sv;
        bit   acc;
        bit   re;
        bit [5:0] vpat;

        modelReset();
        #1;
        checkOutput("reset");
        checkValue("reset.rd_data", 64'(rd_data), 64'(0));
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // Layer 2, continuous stream 0..15
        $display("[TB] load layer 2 with continuous stream");
        applyStimulus(1, 2, 0, 0, 0, 0, 0, 0);
        done_seen = 0;
        ready_cycles = 0;
        for (int i = 0; i < LS * LS; i++) begin
            if (s_ready) ready_cycles++;
            applyStimulus(0, 0, 0, 1, i, 0, 0, 0);
        end
        idle(2);
        checkValue("l2.ready_cycles", 64'(ready_cycles), 64'(16));
        checkValue("l2.done_pulses", 64'(done_seen), 64'(1));

        applyStimulus(0, 0, 0, 0, 0, 1, 2, 1);
        checkValue("l2.rd_valid_early", 64'(rd_valid), 64'(0));
        idle(1);
        exp_col = {8'd13, 8'd9, 8'd5, 8'd1};
        checkValue("l2.rd_valid", 64'(rd_valid), 64'(1));
        checkValue("l2.col1", 64'(rd_data), 64'(exp_col));
        idle(1);

        // Layer 3, s_valid toggling, data 0x10..0x1F
        $display("[TB] load layer 3 with toggling valid");
        applyStimulus(1, 3, 0, 0, 0, 0, 0, 0);
        beats = 0;
        for (int c = 0; c < 64 && beats < LS * LS; c++) begin
            sv  = ((c % 2) == 0);
            acc = sv && s_ready;
            applyStimulus(0, 0, 0, sv, 16 + beats, 0, 0, 0);
            if (acc) beats++;
        end
        checkValue("l3.beats", 64'(beats), 64'(16));
        idle(2);

        // Back-to-back column reads of layer 3
        vpat = '0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 0, 0, 0, (i < 4), 3, i % 4);
            vpat[i] = rd_valid;
            if (i == 3) begin
                exp_col = {8'h1E, 8'h1A, 8'h16, 8'h12};
                checkValue("l3.col2", 64'(rd_data), 64'(exp_col));
            end
        end
        checkValue("l3.valid_pattern", 64'(vpat), 64'(6'b011110));

        // Preload layer 1 with 0xAA, then abort a reload after 6 beats
        $display("[TB] abort scenario on layer 1");
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < LS * LS; i++) applyStimulus(0, 0, 0, 1, 8'hAA, 0, 0, 0);
        idle(2);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        done_seen = 0;
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1, 8'h60 + i, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
        checkValue("abort.busy", 64'(load_busy), 64'(0));
        idle(2);
        checkValue("abort.done_pulses", 64'(done_seen), 64'(0));
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 1);
        idle(1);
        exp_col = {8'hAA, 8'hAA, 8'h65, 8'h61};
        checkValue("abort.col1", 64'(rd_data), 64'(exp_col));
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 1, 1, i);
        idle(2);

        // Reload layer 2: ignored start mid-load, read-during-write of the last word
        $display("[TB] reload layer 2 with collision read");
        applyStimulus(1, 2, 0, 0, 0, 0, 0, 0);
        done_seen = 0;
        for (int i = 0; i < LS * LS; i++) begin
            applyStimulus((i == 5), 0, 0, 1, int'($urandom_range(0, 255)), (i == 15), 2, 3);
        end
        idle(1);
        checkValue("rdw.rd_valid", 64'(rd_valid), 64'(1));
        checkValue("rdw.old_word", 64'(rd_data[3]), 64'(15));
        checkValue("rdw.done_pulses", 64'(done_seen), 64'(1));
        idle(1);

        // Asynchronous reset mid-load and mid-read
        $display("[TB] reset during load and read");
        applyStimulus(1, 3, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, 1, int'($urandom_range(0, 255)), 1, 2, int'($urandom_range(0, 3)));
        end
        checkValue("prerst.rd_valid", 64'(rd_valid), 64'(1));
        #3;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkValue("rst.rd_valid", 64'(rd_valid), 64'(0));
        checkValue("rst.rd_data", 64'(rd_data), 64'(0));
        checkValue("rst.load_busy", 64'(load_busy), 64'(0));
        checkValue("rst.s_ready", 64'(s_ready), 64'(0));
        checkOutput("rst");
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // New load of layer 0 with random valid gaps and concurrent reads of other layers
        $display("[TB] random reload of layer 0");
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        done_seen = 0;
        beats = 0;
        for (int c = 0; c < 200 && beats < LS * LS; c++) begin
            sv  = 1'($urandom_range(0, 1));
            re  = 1'($urandom_range(0, 1));
            acc = sv && s_ready;
            applyStimulus(0, 0, 0, sv, int'($urandom_range(0, 255)), re,
                          int'($urandom_range(1, 3)), int'($urandom_range(0, 3)));
            if (acc) beats++;
        end
        checkValue("reload.beats", 64'(beats), 64'(16));
        idle(2);
        checkValue("reload.done_pulses", 64'(done_seen), 64'(1));

        for (int c = 0; c < 40; c++) begin
            re = 1'($urandom_range(0, 1));
            applyStimulus(0, 0, 0, 0, 0, re, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
